seq_div16: RTL and testbench

Iterative unsigned restoring divider. It is the inverse-operation companion to the team's registered adder/multiplier datapaths in the user project area. It accepts a dividend/divisor pair on a START strobe and produces one quotient bit per clock. It returns the quotient and remainder with a one-cycle DONE pulse. The block is intended to sit behind the user-project IO/LA wiring, beside the existing arithmetic blocks, and shares their single clock domain.

---
 rtl/seq_div16.sv | 121 ++++++++++++
 tb/tb_seq_div16.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div16.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with a registered
// quotient/remainder and a one-cycle done pulse. Divide-by-zero completes immediately.
module seq_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             div0_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        CALC
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             qbit;

    // Trial subtraction includes P's top bit so any stray overflow reads as non-negative.
    always_comb begin
        shifted = {p_q[WIDTH-1:0], d_q[WIDTH-1]};
        diff    = {p_q, d_q[WIDTH-1]} - {2'b00, v_q};
        qbit    = ~diff[WIDTH+1];
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        p_d     = p_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (b_i != '0) begin
                        d_d     = a_i;
                        v_d     = b_i;
                        p_d     = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        q_d    = '1;
                        r_d    = a_i;
                        div0_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                p_d   = qbit ? diff[WIDTH:0] : shifted;
                d_d   = {d_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + 1'b1;
                // The last iteration publishes the freshly shifted D and P directly.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    q_d     = d_d;
                    r_d     = p_d[WIDTH-1:0];
                    div0_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            d_q     <= '0;
            p_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            p_q     <= p_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = done_q;
    assign q_o    = q_q;
    assign r_o    = r_q;
    assign div0_o = div0_q;

endmodule

// File: tb/tb_seq_div16.sv
// Scoreboard bench for seq_div16: the driver pushes hand-computed results, a monitor
// pops and compares them on every done pulse.
module tb_seq_div16;

    localparam int WIDTH = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy, done, div0;
    logic [15:0] q, r;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        div0;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seq_div16 #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start),
        .a_i    (a),
        .b_i    (b),
        .busy_o (busy),
        .done_o (done),
        .q_o    (q),
        .r_o    (r),
        .div0_o (div0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("q", {16'd0, q}, {16'd0, e.q});
                checkOutput("r", {16'd0, r}, {16'd0, e.r});
                checkOutput("div0", {31'd0, div0}, {31'd0, e.div0});
                checkOutput("busy_with_done", {31'd0, busy}, 32'd0);
                if (!e.div0) begin
                    checkOutput("invariant", 32'(q) * 32'(e.b) + 32'(r), {16'd0, e.a});
                    checkOutput("r_lt_b", {31'd0, (r < e.b)}, 32'd1);
                end
            end
        end
    end

    // Issue one request from a negedge and wait for its done, checking latency and busy time.
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic [15:0] eq, input logic [15:0] er, input logic ed);
        int negs;
        int busyCnt;
        exp_t e;
        e.a = va; e.b = vb; e.q = eq; e.r = er; e.div0 = ed;
        sb.push_back(e);
        a = va;
        b = vb;
        start = 1'b1;
        negs = 0;
        busyCnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            negs++;
            if (busy) busyCnt++;
        end while (!done && negs < 40);
        if (!done) checkOutput("done_timeout", 32'(negs), 32'(WIDTH + 1));
        checkOutput("latency", 32'(negs), (vb == 16'd0) ? 32'd1 : 32'(WIDTH + 1));
        checkOutput("busy_cycles", 32'(busyCnt), (vb == 16'd0) ? 32'd0 : 32'(WIDTH));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int cyc;
        logic expectBusy;
        logic [15:0] ra, rb;

        // Reset held for two edges, then twenty idle cycles with everything at zero.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {busy, done, div0, q, r}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_outputs", {busy, done, div0, q, r}, 32'd0);
        end

        // Basic division and result hold.
        applyStimulus(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("hold_q", {16'd0, q}, 32'd142);
        checkOutput("hold_r", {16'd0, r}, 32'd6);

        // Corners.
        applyStimulus(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        applyStimulus(16'd5, 16'd10, 16'd0, 16'd5, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);

        // Divide by zero, then a valid division clears div0.
        @(negedge clk);
        applyStimulus(16'd12345, 16'd0, 16'hFFFF, 16'd12345, 1'b1);
        @(negedge clk);
        applyStimulus(16'd100, 16'd9, 16'd11, 16'd1, 1'b0);

        // Start held high: three results back to back, busy again right after each done.
        @(negedge clk);
        for (int i = 0; i < 3; i++) sb.push_back('{a: 16'd100, b: 16'd9, q: 16'd11, r: 16'd1, div0: 1'b0});
        a = 16'd100;
        b = 16'd9;
        start = 1'b1;
        n = 0;
        cyc = 0;
        expectBusy = 1'b0;
        while (n < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (expectBusy) begin
                checkOutput("b2b_no_bubble", {31'd0, busy}, 32'd1);
                expectBusy = 1'b0;
            end
            if (done) begin
                n++;
                if (n == 3) start = 1'b0;
                else expectBusy = 1'b1;
            end
        end
        start = 1'b0;
        checkOutput("b2b_count", 32'(n), 32'd3);

        // Input changes and a start pulse mid-calculation are ignored.
        @(negedge clk);
        sb.push_back('{a: 16'd1000, b: 16'd7, q: 16'd142, r: 16'd6, div0: 1'b0});
        a = 16'd1000;
        b = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 16'd1;
        b = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'd0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midcalc_done_seen", {31'd0, done}, 32'd1);
        repeat (20) @(negedge clk);

        // Abort mid-calculation by reset; no done may follow.
        a = 16'd1000;
        b = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_outputs", {busy, done, div0, q, r}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(16'd1000, 16'd7, 16'd142, 16'd6, 1'b0);

        // Random sweep with occasional small and zero divisors.
        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (rb == 16'd0) applyStimulus(ra, rb, 16'hFFFF, ra, 1'b1);
            else applyStimulus(ra, rb, ra / rb, ra % rb, 1'b0);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
